// File: rtl/alu_vector_capture.sv
// alu_vector_capture: records ALU transactions as packed 14-bit words
// {z, ctrl, b, a} and plays them back in capture order over a valid/ready
// read port.
//
// Build option: define ALU_CAP_WRAP_EN for circular capture (the oldest
// entry is overwritten when full and only stop ends capture). Without it,
// capture stops once the buffer is full.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The write side (in_valid/in_ready) is only live in CAPTURE.
// The read side holds rd_valid and rd_data stable until rd_ready is seen.

module alu_vector_capture #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_a,
  input  logic [3:0]        in_b,
  input  logic [1:0]        in_ctrl,
  input  logic [3:0]        in_z,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [13:0]       rd_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_d;
  logic [13:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_inc;
  logic [ADDR_W:0]   count_d;
  logic              overflow_d;
  logic              done_d;
  logic              rd_valid_d;
  logic [13:0]       rd_data_d;
  logic              full;
  logic              wr_en;
  logic              cap_exit;
  logic [13:0]       wr_word;

  assign full       = (count == CNT_FULL);
  assign rd_ptr_inc = rd_ptr + PTR_ONE;
  assign wr_word    = {in_z, in_ctrl, in_b, in_a};
  assign busy       = (state != IDLE);

`ifdef ALU_CAP_WRAP_EN
  assign in_ready = (state == CAPTURE);
  assign cap_exit = stop;
`else
  assign in_ready = (state == CAPTURE) && !full;
  // A full buffer spends one cycle in CAPTURE with in_ready low (so an
  // offered word can be flagged as overflow) and then moves to DRAIN.
  assign cap_exit = stop || full;
`endif

  assign wr_en = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, pointer, count, flag and read-port computation.
  always_comb begin
    state_d    = state;
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr;
    count_d    = count;
    overflow_d = overflow;
    done_d     = 1'b0;
    rd_valid_d = rd_valid;
    rd_data_d  = rd_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_d    = CAPTURE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr + PTR_ONE;
`ifdef ALU_CAP_WRAP_EN
          if (full) begin
            // Overwrite the oldest word; the read pointer follows.
            rd_ptr_d   = rd_ptr_inc;
            overflow_d = 1'b1;
          end else begin
            count_d = count + CNT_ONE;
          end
`else
          count_d = count + CNT_ONE;
`endif
        end
`ifndef ALU_CAP_WRAP_EN
        if (in_valid && full) begin
          overflow_d = 1'b1;
        end
`endif
        // The exit decision sees the word written in this same cycle.
        if (cap_exit) begin
          if (count_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!rd_valid) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem[rd_ptr];
        end else if (rd_ready) begin
          rd_ptr_d = rd_ptr_inc;
          count_d  = count - CNT_ONE;
          if (count == CNT_ONE) begin
            rd_valid_d = 1'b0;
            state_d    = IDLE;
            done_d     = 1'b1;
          end else begin
            // Prefetch the next word so reads stream with no bubble.
            rd_data_d = mem[rd_ptr_inc];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointers, count, flags and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      count    <= count_d;
      overflow <= overflow_d;
      done     <= done_d;
      rd_valid <= rd_valid_d;
      rd_data  <= rd_data_d;
    end
  end

  // Capture memory; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_word;
    end
  end

endmodule

// File: tb/tb_alu_vector_capture.sv
// Self-checking bench for alu_vector_capture. A queue-level behavioural
// model predicts every output each cycle; directed tests pin the model with
// hand-computed words and randomized rounds exercise the rest.
// Define ALU_CAP_WRAP_EN to check the circular-capture build.

module tb_alu_vector_capture;

`ifdef ALU_CAP_WRAP_EN
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam bit WRAP  = 1'b1;
`else
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam bit WRAP  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_a = '0;
  logic [3:0]    in_b = '0;
  logic [1:0]    in_ctrl = '0;
  logic [3:0]    in_z = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [13:0]   rd_data;
  logic [AW:0]   count;
  logic          busy;
  logic          overflow;
  logic          done;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  alu_vector_capture #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_ctrl(in_ctrl), .in_z(in_z), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .count(count), .busy(busy), .overflow(overflow),
    .done(done)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 capture, 2 drain. exp_q holds the words in capture order.
  int          m_mode = 0;
  logic [13:0] exp_q[$];
  bit          m_ovf = 1'b0;
  bit          m_done = 1'b0;
  bit          m_rdv = 1'b0;
  logic [13:0] m_rdd = '0;
  int          m_sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      exp_q.delete();
      m_ovf = 1'b0;
      m_done = 1'b0;
      m_rdv = 1'b0;
      m_rdd = '0;
    end else begin
      m_done = 1'b0;
      case (m_mode)
        0: if (start) begin
          exp_q.delete();
          m_ovf = 1'b0;
          m_mode = 1;
        end
        1: begin
          m_sz = exp_q.size();
          if (in_valid) begin
            if (m_sz < DEPTH) exp_q.push_back({in_z, in_ctrl, in_b, in_a});
            else if (WRAP) begin
              void'(exp_q.pop_front());
              exp_q.push_back({in_z, in_ctrl, in_b, in_a});
              m_ovf = 1'b1;
            end else m_ovf = 1'b1;
          end
          if (stop || (!WRAP && m_sz == DEPTH)) begin
            if (exp_q.size() == 0) begin
              m_mode = 0;
              m_done = 1'b1;
            end else m_mode = 2;
          end
        end
        default: begin
          if (!m_rdv) begin
            m_rdv = 1'b1;
            m_rdd = exp_q[0];
          end else if (rd_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
              m_rdv = 1'b0;
              m_mode = 0;
              m_done = 1'b1;
            end else m_rdd = exp_q[0];
          end
        end
      endcase
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (m_mode == 1) && (WRAP || exp_q.size() < DEPTH)});
      check("count", 32'(count), exp_q.size());
      check("busy", {31'd0, busy}, {31'd0, m_mode != 0});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("rd_valid", {31'd0, rd_valid}, {31'd0, m_rdv});
      if (m_rdv) check("rd_data", 32'(rd_data), 32'(m_rdd));
    end
  end

  // ---------------- driver tasks ----------------
  logic [13:0] got[$];
  int          dn;

  function automatic logic [13:0] pack(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] c, input logic [3:0] z);
    return {z, c, b, a};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] c, input logic [3:0] z, input bit s);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_ctrl = c; in_z = z;
    stop = s;
    tick();
    in_valid = 1'b0;
    stop = 1'b0;
  endtask

  // Read until the block returns to IDLE, collecting handshaken words.
  task automatic drain(input int ready_pct);
    int budget;
    got.delete();
    dn = 0;
    budget = 4 * DEPTH + 50;
    while (budget > 0) begin
      rd_ready = ($urandom_range(0, 99) < ready_pct);
      if (done) dn++;
      if (!busy) break;
      if (rd_valid && rd_ready) got.push_back(rd_data);
      tick();
      budget--;
    end
    rd_ready = 1'b0;
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy still %0b, required 0", busy);
    end
  endtask

  // ---------------- test sequence ----------------
  logic [13:0] fill_w [DEPTH];
  logic [13:0] hold;
  logic [13:0] w_a, w_b;

  initial begin
    // Reset state.
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_count", 32'(count), 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_done", {31'd0, done}, 0);
    tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Basic capture and drain.
    do_start();
    do_write(4'd3, 4'd5, 2'd0, 4'd8, 1'b0);
    do_write(4'b1000, 4'd1, 2'd1, 4'd7, 1'b0);
    do_write(4'd2, 4'd2, 2'd2, 4'd2, 1'b0);
    do_stop();
    drain(100);
    check("basic_n", got.size(), 3);
    check("basic_w0", 32'(got[0]), 32'(14'b10_0000_0101_0011));
    check("basic_w1", 32'(got[1]), 32'(14'b01_1101_0001_1000));
    check("basic_w2", 32'(got[2]), 32'(14'b00_1010_0010_0010));
    check("basic_done_pulses", dn, 1);
    check("basic_count", 32'(count), 0);

`ifndef ALU_CAP_WRAP_EN
    // Fill to full, overflow in the full cycle, then backpressure and stream.
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      fill_w[i] = 14'($urandom);
      do_write(fill_w[i][3:0], fill_w[i][7:4], fill_w[i][9:8], fill_w[i][13:10], 1'b0);
    end
    check("full_in_ready", {31'd0, in_ready}, 0);
    check("full_count", 32'(count), DEPTH);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("full_overflow", {31'd0, overflow}, 1);
    tick();
    hold = rd_data;
    check("bp_first_word", 32'(hold), 32'(fill_w[0]));
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rd_valid}, 1);
      check("bp_stable", 32'(rd_data), 32'(hold));
      tick();
    end
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("stream_valid", {31'd0, rd_valid}, 1);
      check("stream_data", 32'(rd_data), 32'(fill_w[i]));
      tick();
    end
    rd_ready = 1'b0;
    check("stream_done", {31'd0, done}, 1);
    check("stream_overflow_held", {31'd0, overflow}, 1);
    tick();
`endif

    // Empty exit: start then immediate stop.
    do_start();
    check("empty_ovf_cleared", {31'd0, overflow}, 0);
    do_stop();
    check("empty_done", {31'd0, done}, 1);
    check("empty_busy", {31'd0, busy}, 0);
    check("empty_rd_valid", {31'd0, rd_valid}, 0);
    tick();
    check("empty_done_once", {31'd0, done}, 0);

    // Stop together with an accepted write: that word drains last.
    w_a = pack(4'hA, 4'h1, 2'd3, 4'hB);
    w_b = pack(4'h6, 4'h9, 2'd1, 4'hF);
    do_start();
    do_write(w_a[3:0], w_a[7:4], w_a[9:8], w_a[13:10], 1'b0);
    do_write(w_b[3:0], w_b[7:4], w_b[9:8], w_b[13:10], 1'b1);
    drain(100);
    check("stopwr_n", got.size(), 2);
    check("stopwr_last", 32'(got[1]), 32'(w_b));

    // Reset mid-drain after two reads.
    do_start();
    for (int i = 0; i < 3; i++) do_write(4'(i), 4'(i + 1), 2'(i), 4'(i + 2), 1'b0);
    do_stop();
    rd_ready = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 0);
    check("arst_rd_valid", {31'd0, rd_valid}, 0);
    check("arst_rd_data", 32'(rd_data), 0);
    check("arst_count", 32'(count), 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_overflow", {31'd0, overflow}, 0);
    check("arst_done", {31'd0, done}, 0);
    rd_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    w_a = pack(4'h5, 4'hC, 2'd2, 4'h3);
    do_start();
    do_write(w_a[3:0], w_a[7:4], w_a[9:8], w_a[13:10], 1'b1);
    drain(100);
    check("arst_recap_n", got.size(), 1);
    check("arst_recap_w", 32'(got[0]), 32'(w_a));

`ifdef ALU_CAP_WRAP_EN
    // Circular capture: 6 writes into 4 entries keep the newest four.
    do_start();
    for (int i = 0; i < 6; i++) do_write(4'(i), 4'($urandom), 2'($urandom), 4'($urandom), 1'b0);
    do_stop();
    drain(100);
    check("wrap_n", got.size(), 4);
    for (int i = 0; i < 4; i++) check("wrap_a", 32'(got[i][3:0]), i + 2);
    check("wrap_overflow", {31'd0, overflow}, 1);
`endif

    // Randomized rounds, checked every cycle by the model.
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(0, DEPTH + 4);
      do_start();
      for (int j = 0; j < n; j++) begin
        in_valid = ($urandom_range(0, 99) < 70);
        in_a = 4'($urandom); in_b = 4'($urandom);
        in_ctrl = 2'($urandom); in_z = 4'($urandom);
        stop = (j == n - 1) && ($urandom_range(0, 1) == 1);
        start = ($urandom_range(0, 99) < 8);
        rd_ready = ($urandom_range(0, 99) < 50);
        tick();
      end
      in_valid = 1'b0;
      stop = 1'b0;
      start = 1'b0;
      rd_ready = 1'b0;
      do_stop();
      drain(60);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_vector_capture.md
# alu_vector_capture

Hardware capture buffer for the 4-bit ALU: records each ALU transaction (operand A, operand B, ctrl, result Z) as one packed 14-bit word and plays the words back in order over a valid/ready read port. It writes the same vector format that the ALU vector bench reads: {Z[13:10], ctrl[9:8], B[7:4], A[3:0]}, one word per line. It sits beside the ALU instance and feeds a host or dump path that regenerates expected-result vector files from silicon or a reference model.

## Interface
- DEPTH, 256, number of capture entries; power of two, 2..256
- ADDR_W, 8, log2(DEPTH)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; arms capture from IDLE
- stop  input  1  one-cycle pulse; ends capture early
- in_valid  input  1  ALU transaction present this cycle
- in_ready  output  1  capture will accept in_valid this cycle
- in_a  input  4  ALU operand A
- in_b  input  4  ALU operand B
- in_ctrl  input  2  ALU opcode
- in_z  input  4  ALU result
- rd_valid  output  1  rd_data holds a captured word
- rd_ready  input  1  consumer takes rd_data this cycle
- rd_data  output  14  {in_z, in_ctrl, in_b, in_a} as captured
- count  output  ADDR_W+1  words held, 0..DEPTH
- busy  output  1  state is not IDLE
- overflow  output  1  sticky; a transaction was offered while full in CAPTURE
- done  output  1  one-cycle pulse when DRAIN returns to IDLE

## Operation
- States: IDLE, CAPTURE, DRAIN. Reset -> IDLE.
- IDLE: start -> CAPTURE; clears count, write/read pointers and overflow. stop, in_valid and rd_ready are ignored.
- CAPTURE: in_ready = (count != DEPTH). A write occurs on in_valid && in_ready, into mem[wr_ptr]; wr_ptr++ (mod DEPTH); count++.
- CAPTURE exit: stop, or a write that makes count reach DEPTH, moves to DRAIN next cycle. If count is 0 at exit, go to IDLE and pulse done instead.
- in_valid while full in CAPTURE sets overflow. overflow holds until the next accepted start or reset.
- DRAIN: words are presented in capture order from rd_ptr. A read occurs on rd_valid && rd_ready; rd_ptr++; count--. The read of the last word moves to IDLE and pulses done.
- Simultaneous events:
  - stop together with an accepted in_valid: the word is written, then the block exits.
  - start in CAPTURE or DRAIN is ignored.
  - stop in DRAIN is ignored.
- Packing is bit-exact; no arithmetic on fields. count width is ADDR_W+1, so the value DEPTH is representable.
- Memory contents are not reset. Only pointers, count and flags are reset.

## Timing
- Reset values: in_ready=0, rd_valid=0, rd_data=0, count=0, busy=0, overflow=0, done=0.
- Reset is asynchronous and active-low; asserting it mid-operation returns to IDLE immediately and discards captured data.
- in_ready is combinational from state and count.
- Writes take effect at the clock edge; count updates in the same edge.
- rd_data and rd_valid are registered.
- rd_valid rises 1 cycle after entering DRAIN.
- After each read handshake, the next word appears the following cycle with no bubble, so sustained throughput is 1 word/cycle.
- rd_data holds stable while rd_valid && !rd_ready.
- done is asserted the cycle after the final read handshake, or the cycle after an empty exit. busy drops in that same cycle.

## Configuration
- ALU_CAP_WRAP_EN defined: circular capture.
  - in_ready is 1 throughout CAPTURE.
  - A write when full overwrites the oldest entry: rd_ptr++ and count stays at DEPTH.
  - Reaching full does not end capture; only stop does.
  - overflow is set on the first overwrite.
  - DRAIN starts from the oldest surviving word.
- ALU_CAP_WRAP_EN undefined: stop-on-full behaviour as described in Operation.

## Test plan
- Basic capture and drain:
  - start, then 3 writes (A=3,B=5,ctrl=0,Z=8), (A=-8,B=1,ctrl=1,Z=7), (A=2,B=2,ctrl=2,Z=2), then stop.
  - Required: DRAIN yields 14'b10_0000_0101_0011 first, then the other two in order; done pulses once; count returns to 0.
- Fill to full (wrap undefined):
  - DEPTH writes.
  - Required: in_ready=0 after the last write; DRAIN follows with no stop; a further in_valid in that full cycle sets overflow.
- Read backpressure:
  - Hold rd_ready=0 for 5 cycles in DRAIN.
  - Required: rd_data stable and rd_valid=1 throughout; with rd_ready tied 1, words stream 1 per cycle.
- Boundary events:
  - start then immediate stop with no writes -> done pulses 1 cycle later, no rd_valid.
  - stop coinciding with in_valid -> that word is drained last.
- Reset mid-DRAIN:
  - Drop rst_n after 2 reads.
  - Required: all outputs at reset values asynchronously; the next start captures from address 0.
- Wrap (ALU_CAP_WRAP_EN, DEPTH=4):
  - 6 writes with A=0..5, then stop.
  - Required: drain yields A=2,3,4,5 and overflow=1.
